wb_trace_buffer: RTL and testbench

Commit-trace capture block for the single-cycle CPU `top`. Sits directly downstream of `top`, sampling its debug outputs (pc, register write-back, store signals) every clock. Records architecturally visible events, register writes and stores, into a FIFO drained through a valid/ready port. Also detects the terminal self-loop (`j .`) and freezes capture, so a bench or host can read back a complete execution trace.

---
 rtl/wb_trace_buffer_if.sv | 10 +
 rtl/wb_trace_buffer.sv | 124 ++++++++++++
 tb/tb_wb_trace_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_buffer_if.sv
// Trace drain port of wb_trace_buffer: valid/ready handshake carrying one 49-bit entry.
// The buffer drives valid/data (master); the consumer drives ready (slave).
interface wb_trace_buffer_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [48:0] tr_data;

    modport master (output tr_valid, output tr_data, input tr_ready);
    modport slave  (input tr_valid, input tr_data, output tr_ready);
endinterface

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture for the single-cycle CPU: queues register writes and stores
// into a FIFO and freezes capture once the pc sits in a terminal self-loop.
module wb_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           pc,
    input  logic                 wea_reg,
    input  logic [4:0]           write_reg,
    input  logic [31:0]          r3_din,
    input  logic                 MemWrite,
    input  logic [31:0]          alu_out,
    input  logic [31:0]          reg_out2,
    wb_trace_buffer_if.master    tr,
    output logic                 halted,
    output logic                 overflow,
    output logic [31:0]          cycle_cnt,
    output logic [15:0]          wb_cnt,
    output logic [15:0]          st_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [48:0]   mem [DEPTH];
    logic [48:0]   last_q;
    logic [7:0]    pc_q;
    logic          primed;
    logic [7:0]    stall_cnt;
    logic          overflow_q;
    logic [31:0]   cycle_q;
    logic [15:0]   wb_q, st_q;

    logic          running, reg_ev, st_ev, empty, full, pop, push, push_ok;
    logic          pc_same, halt_hit;
    logic [48:0]   entry;
    logic          unused_alu_hi;

    assign unused_alu_hi = ^alu_out[31:8];

    assign running  = (state_q == S_RUN);
    assign reg_ev   = running & wea_reg & (write_reg != 5'd0);
    assign st_ev    = running & MemWrite;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = ~empty & tr.tr_ready;
    assign push     = reg_ev | st_ev;
    // A pop on the same edge frees the slot the push is about to take.
    assign push_ok  = push & (~full | pop);
    assign entry    = reg_ev ? {1'b0, pc, 3'b000, write_reg, r3_din}
                             : {1'b1, pc, alu_out[7:0], reg_out2};
    assign pc_same  = running & primed & (pc == pc_q);
    assign halt_hit = pc_same && (({1'b0, stall_cnt} + 9'd1) == 9'(HALT_CYCLES));

    // Empty FIFO presents the last popped entry so tr_data never jumps to stale slots.
    assign tr.tr_valid = ~empty;
    assign tr.tr_data  = empty ? last_q : mem[rd_ptr[AW-1:0]];

    assign halted    = (state_q == S_HALTED);
    assign overflow  = overflow_q;
    assign cycle_cnt = cycle_q;
    assign wb_cnt    = wb_q;
    assign st_cnt    = st_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (halt_hit) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_q     <= '0;
            pc_q       <= '0;
            primed     <= 1'b0;
            stall_cnt  <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            wb_q       <= '0;
            st_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                last_q <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            // The store loses to the register write when both fire on one edge.
            if ((reg_ev & st_ev) | (push & ~push_ok)) begin
                overflow_q <= 1'b1;
            end
            if (running) begin
                cycle_q   <= cycle_q + 32'd1;
                primed    <= 1'b1;
                pc_q      <= pc;
                stall_cnt <= pc_same ? stall_cnt + 8'd1 : 8'd0;
                if (reg_ev && wb_q != 16'hFFFF) wb_q <= wb_q + 16'd1;
                if (st_ev && st_q != 16'hFFFF) st_q <= st_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: a queue-based reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_wb_trace_buffer;
    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc;
    logic        wea_reg;
    logic [4:0]  write_reg;
    logic [31:0] r3_din;
    logic        MemWrite;
    logic [31:0] alu_out;
    logic [31:0] reg_out2;
    logic        halted, overflow;
    logic [31:0] cycle_cnt;
    logic [15:0] wb_cnt, st_cnt;

    wb_trace_buffer_if tr_if ();

    wb_trace_buffer #(.DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .wea_reg   (wea_reg),
        .write_reg (write_reg),
        .r3_din    (r3_din),
        .MemWrite  (MemWrite),
        .alu_out   (alu_out),
        .reg_out2  (reg_out2),
        .tr        (tr_if),
        .halted    (halted),
        .overflow  (overflow),
        .cycle_cnt (cycle_cnt),
        .wb_cnt    (wb_cnt),
        .st_cnt    (st_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [7:0] idle_pc = 8'd1;

    // Reference model state
    logic [48:0] q[$];
    logic [48:0] m_last;
    bit          m_halted, m_ovf;
    logic [31:0] m_cyc;
    logic [15:0] m_wb, m_st;
    int          m_run_len;
    logic [7:0]  m_last_pc;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [7:0] p, input logic wea,
                                 input logic [4:0] wr, input logic [31:0] din, input logic mw,
                                 input logic [31:0] alu, input logic [31:0] d2, input logic rdy);
        rst_n           = rst;
        pc              = p;
        wea_reg         = wea;
        write_reg       = wr;
        r3_din          = din;
        MemWrite        = mw;
        alu_out         = alu;
        reg_out2        = d2;
        tr_if.tr_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idleStep(input logic rdy);
        idle_pc = idle_pc + 8'd2;
        applyStimulus(1'b1, idle_pc, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, rdy);
    endtask

    // Model: events, FIFO as a queue, halt as a run of identical pc samples.
    always @(posedge clk) begin
        bit          was_full, do_pop, is_wb, is_st;
        logic [48:0] ent;
        if (!rst_n) begin
            q.delete();
            m_last    = '0;
            m_halted  = 1'b0;
            m_ovf     = 1'b0;
            m_cyc     = '0;
            m_wb      = '0;
            m_st      = '0;
            m_run_len = 0;
            m_last_pc = '0;
        end else begin
            was_full = (q.size() == DEPTH);
            do_pop   = (q.size() != 0) && tr_if.tr_ready;
            if (do_pop) m_last = q.pop_front();
            if (!m_halted) begin
                m_cyc = m_cyc + 32'd1;
                is_wb = wea_reg && (write_reg != 5'd0);
                is_st = MemWrite;
                if (is_wb && m_wb != 16'hFFFF) m_wb = m_wb + 16'd1;
                if (is_st && m_st != 16'hFFFF) m_st = m_st + 16'd1;
                if (is_wb || is_st) begin
                    ent = is_wb ? {1'b0, pc, 3'b000, write_reg, r3_din}
                                : {1'b1, pc, alu_out[7:0], reg_out2};
                    if (is_wb && is_st) m_ovf = 1'b1;
                    if (was_full && !do_pop) m_ovf = 1'b1;
                    else q.push_back(ent);
                end
                if (m_run_len > 0 && pc == m_last_pc) m_run_len++;
                else m_run_len = 1;
                m_last_pc = pc;
                if (m_run_len == HALT_CYCLES + 1) m_halted = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("tr_valid", 64'(tr_if.tr_valid), 64'(q.size() != 0));
            checkOutput("tr_data", 64'(tr_if.tr_data), 64'((q.size() != 0) ? q[0] : m_last));
            checkOutput("halted", 64'(halted), 64'(m_halted));
            checkOutput("overflow", 64'(overflow), 64'(m_ovf));
            checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
            checkOutput("wb_cnt", 64'(wb_cnt), 64'(m_wb));
            checkOutput("st_cnt", 64'(st_cnt), 64'(m_st));
        end
    end

    initial begin
        // Reset held three edges with random inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
                          $urandom, $urandom, 1'($urandom));
            chk_en = 1'b1;
        end
        checkOutput("rst_valid", 64'(tr_if.tr_valid), 64'd0);
        checkOutput("rst_data", 64'(tr_if.tr_data), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_counts", {cycle_cnt, wb_cnt, st_cnt}, 64'd0);
        idleStep(1'b1);
        checkOutput("first_cycle", 64'(cycle_cnt), 64'd1);

        // Write capture, then write to r0 which must be ignored
        applyStimulus(1'b1, 8'h04, 1'b1, 5'd8, 32'h5, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("wr_valid", 64'(tr_if.tr_valid), 64'd1);
        checkOutput("wr_data", 64'(tr_if.tr_data), 64'({1'b0, 8'h04, 8'h08, 32'h5}));
        applyStimulus(1'b1, 8'h06, 1'b1, 5'd0, 32'h77, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("r0_valid", 64'(tr_if.tr_valid), 64'd0);
        checkOutput("r0_wbcnt", 64'(wb_cnt), 64'd1);
        checkOutput("r0_hold", 64'(tr_if.tr_data), 64'({1'b0, 8'h04, 8'h08, 32'h5}));

        // Store capture, then simultaneous register write and store
        applyStimulus(1'b1, 8'h0C, 1'b0, 5'd0, 32'd0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        checkOutput("st_data", 64'(tr_if.tr_data), 64'({1'b1, 8'h0C, 8'h10, 32'hDEADBEEF}));
        applyStimulus(1'b1, 8'h10, 1'b1, 5'd3, 32'h33, 1'b1, 32'h20, 32'h44, 1'b1);
        checkOutput("both_data", 64'(tr_if.tr_data), 64'({1'b0, 8'h10, 8'h03, 32'h33}));
        checkOutput("both_ovf", 64'(overflow), 64'd1);
        checkOutput("both_counts", 64'({wb_cnt, st_cnt}), 64'({16'd2, 16'd2}));
        idleStep(1'b1);

        // Full FIFO: 18 writes with no drain
        applyStimulus(1'b0, 8'hFF, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + 2 * i), 1'b1, 5'(i % 31 + 1), 32'hA000_0000 + 32'(i),
                          1'b0, 32'd0, 32'd0, 1'b0);
        end
        checkOutput("full_ovf", 64'(overflow), 64'd1);
        checkOutput("full_wbcnt", 64'(wb_cnt), 64'd18);
        checkOutput("full_head", 64'(tr_if.tr_data), 64'({1'b0, 8'h40, 8'h01, 32'hA000_0000}));
        applyStimulus(1'b1, 8'h91, 1'b1, 5'd3, 32'hCAFE, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("fullpop_wbcnt", 64'(wb_cnt), 64'd19);
        for (int i = 0; i < 16; i++) idleStep(1'b1);
        checkOutput("fullpop_empty", 64'(tr_if.tr_valid), 64'd0);
        checkOutput("fullpop_last", 64'(tr_if.tr_data), 64'({1'b0, 8'h91, 8'h03, 32'hCAFE}));

        // Reset mid-drain
        applyStimulus(1'b0, 8'hFF, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + 2 * i), 1'b1, 5'(i + 1), 32'(i), 1'b0, 32'd0, 32'd0, 1'b0);
        end
        idleStep(1'b1);
        applyStimulus(1'b0, 8'hFF, 1'b1, 5'd1, 32'd1, 1'b1, 32'd1, 32'd1, 1'b1);
        checkOutput("mid_valid", 64'(tr_if.tr_valid), 64'd0);
        checkOutput("mid_halted", 64'(halted), 64'd0);
        checkOutput("mid_data", 64'(tr_if.tr_data), 64'd0);
        applyStimulus(1'b1, 8'h30, 1'b1, 5'd9, 32'h99, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("resume_data", 64'(tr_if.tr_data), 64'({1'b0, 8'h30, 8'h09, 32'h99}));

        // Halt on pc 0,4,8,8,8,8,8
        applyStimulus(1'b0, 8'hFF, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            logic [7:0] hp;
            hp = (i == 0) ? 8'h00 : (i == 1) ? 8'h04 : 8'h08;
            applyStimulus(1'b1, hp, 1'b1, 5'(i + 1), 32'(i * 16), 1'b0, 32'd0, 32'd0, 1'b0);
            if (i == 5) checkOutput("pre_halt", 64'(halted), 64'd0);
        end
        checkOutput("halt", 64'(halted), 64'd1);
        checkOutput("halt_cycles", 64'(cycle_cnt), 64'd7);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'h08, 1'b1, 5'd2, 32'h55, 1'b1, 32'h8, 32'h66, 1'b0);
        end
        checkOutput("frozen_cycles", 64'(cycle_cnt), 64'd7);
        checkOutput("frozen_counts", 64'({wb_cnt, st_cnt}), 64'({16'd7, 16'd0}));
        for (int i = 0; i < 8; i++) idleStep(1'b1);
        checkOutput("halt_drained", 64'(tr_if.tr_valid), 64'd0);
        checkOutput("halt_last", 64'(tr_if.tr_data), 64'({1'b0, 8'h08, 8'h07, 32'h60}));

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
